// File: rtl/mul_booth_r4_if.sv
// Operand/handshake bundle for mul_booth_r4: the controller side uses the master
// modport and the multiplier uses the slave modport.
interface mul_booth_r4_if #(
    parameter int WIDTH = 64
);
    logic                 op_start;
    logic                 op_clear;
    logic                 op_signed;
    logic [WIDTH-1:0]     multiplier;
    logic [WIDTH-1:0]     multiplicand;
    logic                 op_busy;
    logic                 op_done;
    logic [2*WIDTH-1:0]   result;

    modport master (
        output op_start, op_clear, op_signed, multiplier, multiplicand,
        input  op_busy, op_done, result
    );

    modport slave (
        input  op_start, op_clear, op_signed, multiplier, multiplicand,
        output op_busy, op_done, result
    );
endinterface

// File: rtl/mul_booth_r4.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, signed or unsigned operands.
// Optional MUL_ZERO_SKIP_EN: a zero operand at start goes straight to DONE with result 0.
module mul_booth_r4 #(
    parameter int WIDTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    mul_booth_r4_if.slave bus
);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = 2 * WIDTH + 4;
    localparam int NDIG = WIDTH / 2 + 1;
    localparam int CW   = $clog2(NDIG + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic               busy_s;
    logic               done_s;
    logic               busy_r;
    logic               done_r;
    logic [CW-1:0]      cnt_r;
    logic [EW:0]        mplier_r;
    logic [AW-1:0]      mcand_r;
    logic [AW-1:0]      acc_r;
    logic [AW-1:0]      sum_s;
    logic [2*WIDTH-1:0] result_r;
    logic               zero_op_s;
    logic               last_digit_s;

    // Multiple of the (already weight-aligned) multiplicand selected by one Booth group.
    function automatic logic [AW-1:0] booth_multiple(input logic [2:0] grp, input logic [AW-1:0] m);
        case (grp)
            3'b001, 3'b010: booth_multiple = m;
            3'b011:         booth_multiple = {m[AW-2:0], 1'b0};
            3'b100:         booth_multiple = {AW{1'b0}} - {m[AW-2:0], 1'b0};
            3'b101, 3'b110: booth_multiple = {AW{1'b0}} - m;
            default:        booth_multiple = {AW{1'b0}};
        endcase
    endfunction

`ifdef MUL_ZERO_SKIP_EN
    assign zero_op_s = (bus.multiplier == {WIDTH{1'b0}}) || (bus.multiplicand == {WIDTH{1'b0}});
`else
    assign zero_op_s = 1'b0;
`endif

    // The multiplicand register shifts left two bits per digit, so it already carries weight 4^k.
    assign sum_s        = acc_r + booth_multiple(mplier_r[2:0], mcand_r);
    assign last_digit_s = (cnt_r == CW'(NDIG - 1));

    // State and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; clear beats start in every state.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.op_clear) begin
                    next_state_s = ST_IDLE;
                end else if (bus.op_start) begin
                    next_state_s = zero_op_s ? ST_DONE : ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (bus.op_clear) begin
                    next_state_s = ST_IDLE;
                end else if (last_digit_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_EXEC;
                end
            end
            ST_DONE: begin
                if (bus.op_clear) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Status flags decoded from the upcoming state so they register in step with it.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (next_state_s)
            ST_EXEC: busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand capture, digit iteration and result load.
    always_ff @(posedge clk) begin
        if (reset || bus.op_clear) begin
            cnt_r    <= {CW{1'b0}};
            mplier_r <= {(EW + 1){1'b0}};
            mcand_r  <= {AW{1'b0}};
            acc_r    <= {AW{1'b0}};
            result_r <= {(2 * WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.op_start) begin
                        cnt_r    <= {CW{1'b0}};
                        acc_r    <= {AW{1'b0}};
                        result_r <= {(2 * WIDTH){1'b0}};
                        mplier_r <= {{2{bus.op_signed & bus.multiplier[WIDTH-1]}}, bus.multiplier, 1'b0};
                        mcand_r  <= {{(AW - WIDTH){bus.op_signed & bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                    end
                end
                ST_EXEC: begin
                    acc_r    <= sum_s;
                    cnt_r    <= cnt_r + CW'(1);
                    mplier_r <= {2'b00, mplier_r[EW:2]};
                    mcand_r  <= {mcand_r[AW-3:0], 2'b00};
                    if (last_digit_s) begin
                        result_r <= sum_s[2*WIDTH-1:0];
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign bus.op_busy = busy_r;
    assign bus.op_done = done_r;
    assign bus.result  = result_r;
endmodule

// File: tb/tb_mul_booth_r4.sv
// Self-checking bench for mul_booth_r4 at WIDTH=8 and WIDTH=64 against an arithmetic product model.
module tb_mul_booth_r4;
    localparam int N8  = 5;
    localparam int N64 = 33;
`ifdef MUL_ZERO_SKIP_EN
    localparam bit ZSKIP = 1'b1;
`else
    localparam bit ZSKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mul_booth_r4_if #(.WIDTH(8))  b8 ();
    mul_booth_r4_if #(.WIDTH(64)) b64 ();

    mul_booth_r4 #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(b8));
    mul_booth_r4 #(.WIDTH(64)) dut64 (.clk(clk), .reset(reset), .bus(b64));

    function automatic logic [15:0] ref8(input logic s, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = s ? {{8{a[7]}}, a} : {8'h00, a};
        eb = s ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    function automatic logic [127:0] ref64(input logic s, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb;
        ea = s ? {{64{a[63]}}, a} : {64'h0, a};
        eb = s ? {{64{b[63]}}, b} : {64'h0, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic s, input logic [7:0] a, input logic [7:0] b);
        int          edges;
        int          exp_edges;
        logic [15:0] exp_p;
        exp_p     = ref8(s, a, b);
        exp_edges = (ZSKIP && (a == 8'h00 || b == 8'h00)) ? 0 : N8;
        b8.op_signed = s;
        b8.multiplier = a;
        b8.multiplicand = b;
        b8.op_start = 1'b1;
        tick();
        b8.op_start = 1'b0;
        b8.multiplier = 8'($urandom);
        b8.multiplicand = 8'($urandom);
        b8.op_signed = 1'($urandom_range(0, 1));
        edges = 0;
        while (b8.op_done !== 1'b1 && edges < 40) begin
            check({tag, ":busy"}, 128'(b8.op_busy), 128'(1'b1));
            tick();
            edges++;
        end
        check({tag, ":latency"}, 128'(edges), 128'(exp_edges));
        check({tag, ":done"}, 128'(b8.op_done), 128'(1'b1));
        check({tag, ":busy_at_done"}, 128'(b8.op_busy), 128'(1'b0));
        check({tag, ":result"}, 128'(b8.result), 128'(exp_p));
    endtask

    task automatic clear8(input string tag);
        b8.op_clear = 1'b1;
        tick();
        b8.op_clear = 1'b0;
        check({tag, ":clr_done"}, 128'(b8.op_done), 128'(1'b0));
        check({tag, ":clr_result"}, 128'(b8.result), 128'(16'h0000));
    endtask

    task automatic run64(input string tag, input logic s, input logic [63:0] a, input logic [63:0] b);
        int           edges;
        int           exp_edges;
        logic [127:0] exp_p;
        exp_p     = ref64(s, a, b);
        exp_edges = (ZSKIP && (a == 64'h0 || b == 64'h0)) ? 0 : N64;
        b64.op_signed = s;
        b64.multiplier = a;
        b64.multiplicand = b;
        b64.op_start = 1'b1;
        tick();
        b64.op_start = 1'b0;
        edges = 0;
        while (b64.op_done !== 1'b1 && edges < 100) begin
            check({tag, ":busy"}, 128'(b64.op_busy), 128'(1'b1));
            if (edges == 10) begin
                b64.multiplier = {$urandom, $urandom};
                b64.multiplicand = {$urandom, $urandom};
                b64.op_signed = ~s;
            end
            tick();
            edges++;
        end
        check({tag, ":latency"}, 128'(edges), 128'(exp_edges));
        check({tag, ":busy_at_done"}, 128'(b64.op_busy), 128'(1'b0));
        check({tag, ":result"}, b64.result, exp_p);
        b64.op_clear = 1'b1;
        tick();
        b64.op_clear = 1'b0;
        check({tag, ":clr_done"}, 128'(b64.op_done), 128'(1'b0));
    endtask

    initial begin
        int edges;
        reset = 1'b1;
        b8.op_start = 1'b0;  b8.op_clear = 1'b0;  b8.op_signed = 1'b0;
        b8.multiplier = 8'h00;  b8.multiplicand = 8'h00;
        b64.op_start = 1'b0; b64.op_clear = 1'b0; b64.op_signed = 1'b0;
        b64.multiplier = 64'h0; b64.multiplicand = 64'h0;
        tick();
        tick();
        reset = 1'b0;
        check("rst:busy8", 128'(b8.op_busy), 128'(1'b0));
        check("rst:done8", 128'(b8.op_done), 128'(1'b0));
        check("rst:result8", 128'(b8.result), 128'(16'h0000));
        check("rst:result64", b64.result, 128'h0);
        tick();

        run8("m128sq", 1'b1, 8'h80, 8'h80);
        check("m128sq:const", 128'(b8.result), 128'(16'h4000));
        tick();
        check("m128sq:hold", 128'(b8.op_done), 128'(1'b1));
        clear8("m128sq");
        run8("u255sq", 1'b0, 8'hFF, 8'hFF);
        check("u255sq:const", 128'(b8.result), 128'(16'hFE01));
        clear8("u255sq");
        run8("s_m1sq", 1'b1, 8'hFF, 8'hFF);
        check("s_m1sq:const", 128'(b8.result), 128'(16'h0001));
        clear8("s_m1sq");
        run8("s_m1x1", 1'b1, 8'hFF, 8'h01);
        check("s_m1x1:const", 128'(b8.result), 128'(16'hFFFF));
        clear8("s_m1x1");

        run64("u64max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        run64("u64max2", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        check("u64max:const", b64.result, 128'h0);
        for (int i = 0; i < 4; i++) begin
            run64("rnd64", 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        end

        // Abort on the third EXEC cycle, then a fresh signed operation.
        b8.op_signed = 1'b0; b8.multiplier = 8'd7; b8.multiplicand = 8'd9; b8.op_start = 1'b1;
        tick();
        b8.op_start = 1'b0;
        tick();
        tick();
        b8.op_clear = 1'b1;
        tick();
        b8.op_clear = 1'b0;
        check("abort:busy", 128'(b8.op_busy), 128'(1'b0));
        check("abort:done", 128'(b8.op_done), 128'(1'b0));
        check("abort:result", 128'(b8.result), 128'(16'h0000));
        tick();
        tick();
        check("abort:idle", 128'(b8.op_busy | b8.op_done), 128'(1'b0));
        run8("s3xm4", 1'b1, 8'd3, 8'hFC);
        check("s3xm4:const", 128'(b8.result), 128'(16'hFFF4));
        clear8("s3xm4");

        // op_start held high through EXEC and DONE.
        b8.op_signed = 1'b0; b8.multiplier = 8'd13; b8.multiplicand = 8'd11; b8.op_start = 1'b1;
        tick();
        edges = 0;
        while (b8.op_done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        check("hold:latency", 128'(edges), 128'(N8));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold:done", 128'(b8.op_done), 128'(1'b1));
            check("hold:busy", 128'(b8.op_busy), 128'(1'b0));
            check("hold:result", 128'(b8.result), 128'(16'd143));
        end
        b8.op_clear = 1'b1;
        tick();
        check("clrstart:done", 128'(b8.op_done), 128'(1'b0));
        tick();
        check("clrstart:busy", 128'(b8.op_busy), 128'(1'b0));
        check("clrstart:done2", 128'(b8.op_done), 128'(1'b0));
        b8.op_clear = 1'b0;
        b8.op_start = 1'b0;
        tick();

        // Reset in the middle of EXEC.
        b8.multiplier = 8'd100; b8.multiplicand = 8'd100; b8.op_start = 1'b1;
        tick();
        b8.op_start = 1'b0;
        tick();
        check("rstmid:busy_before", 128'(b8.op_busy), 128'(1'b1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstmid:busy", 128'(b8.op_busy), 128'(1'b0));
        check("rstmid:done", 128'(b8.op_done), 128'(1'b0));
        check("rstmid:result", 128'(b8.result), 128'(16'h0000));
        tick();

        run8("zero_a", 1'b0, 8'h00, 8'h5A);
        check("zero_a:const", 128'(b8.result), 128'(16'h0000));
        clear8("zero_a");
        run8("zero_b", 1'b1, 8'h5A, 8'h00);
        clear8("zero_b");

        for (int i = 0; i < 30; i++) begin
            run8("rnd8", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            clear8("rnd8");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
